// File: rtl/fir_sample_sequencer_if.sv
// ADC DRP, FIR datapath and DAC signals of the sample sequencer.
// master = sequencer side, slave = ADC/FIR/DAC side.
interface fir_sample_sequencer_if;
   logic        adc_den;
   logic [6:0]  adc_daddr;
   logic        adc_drdy;
   logic [15:0] adc_do;
   logic [7:0]  filt_in;
   logic        filt_en;
   logic [7:0]  filt_out;
   logic [7:0]  dac_data;
   logic        dac_valid;

   modport master (
      output adc_den, adc_daddr, filt_in, filt_en, dac_data, dac_valid,
      input  adc_drdy, adc_do, filt_out
   );

   modport slave (
      input  adc_den, adc_daddr, filt_in, filt_en, dac_data, dac_valid,
      output adc_drdy, adc_do, filt_out
   );
endinterface

// File: rtl/fir_sample_sequencer.sv
// Sample-rate sequencer: on every tick reads one XADC result over DRP,
// pushes the top byte through an external FIR datapath and presents either
// the filtered or the raw byte to the DAC. Tracks DRDY timeouts and ticks
// that arrive while a sample is still in flight.
module fir_sample_sequencer #(
   parameter int unsigned CLK_DIV      = 1000,
   parameter int unsigned FILT_LAT     = 4,
   parameter int unsigned DRDY_TIMEOUT = 255,
   parameter logic [6:0]  ADC_ADDR     = 7'h16,
   parameter logic [15:0] CNT_RST      = 16'h0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   filt_on,
   fir_sample_sequencer_if.master bus,
   output logic                   timeout_err,
   output logic                   overrun_err,
   output logic [15:0]            sample_cnt
);

   // +2 keeps the width non-zero and able to hold DRDY_TIMEOUT itself
   localparam int unsigned        WAIT_W   = $clog2(DRDY_TIMEOUT + 2);
   localparam logic [15:0]        TICK_MAX = 16'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(DRDY_TIMEOUT);
   localparam logic [3:0]         LAT_MAX  = 4'(FILT_LAT - 1);

   if (CLK_DIV < 16 || CLK_DIV > 65535) begin : g_bad_clk_div
      $error("CLK_DIV must be within 16..65535");
   end
   if (FILT_LAT < 1 || FILT_LAT > 15) begin : g_bad_filt_lat
      $error("FILT_LAT must be within 1..15");
   end

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT_DRDY,
      FILTER,
      OUTPUT
   } state_t;

   state_t            state_q;
   logic [15:0]       tick_cnt_q;
   logic [15:0]       tick_cnt_d;
   logic              tick;
   logic [WAIT_W-1:0] wait_q;
   logic [3:0]        lat_q;
   logic              fon_q;
   logic              den_q;
   logic              fen_q;
   logic [7:0]        filt_in_q;
   logic [7:0]        dac_data_q;
   logic              dac_valid_q;
   logic [15:0]       sample_cnt_q;
   logic [15:0]       sample_cnt_d;
   logic              timeout_q;
   logic              overrun_q;
   logic              unused_do_lsbs;

   // low result bits and the 4 LSBs below the 12-bit result are not used
   assign unused_do_lsbs = ^bus.adc_do[7:0];

   // free-running sample-period divider, tick on the terminal count
   always_comb begin
      tick       = (tick_cnt_q == TICK_MAX);
      tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
   end

   // tick counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tick_cnt_q <= 16'd0;
      else     tick_cnt_q <= tick_cnt_d;
   end

   // completed-sample counter wraps naturally at 16 bits
   always_comb begin
      sample_cnt_d = sample_cnt_q + 16'd1;
   end

   // sequencer FSM with all strobes and data outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         lat_q        <= 4'd0;
         fon_q        <= 1'b0;
         den_q        <= 1'b0;
         fen_q        <= 1'b0;
         filt_in_q    <= 8'd0;
         dac_data_q   <= 8'd0;
         dac_valid_q  <= 1'b0;
         sample_cnt_q <= CNT_RST;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         den_q       <= 1'b0;
         fen_q       <= 1'b0;
         dac_valid_q <= 1'b0;
         // a tick while busy is dropped; the running sample is unaffected
         if (tick && state_q != IDLE) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (tick) begin
                  fon_q   <= filt_on;
                  den_q   <= 1'b1;
                  state_q <= READ;
               end
            end
            READ: begin
               wait_q  <= '0;
               state_q <= WAIT_DRDY;
            end
            WAIT_DRDY: begin
               // data wins over timeout on the terminal wait cycle
               if (bus.adc_drdy) begin
                  filt_in_q <= bus.adc_do[15:8];
                  fen_q     <= 1'b1;
                  lat_q     <= 4'd0;
                  state_q   <= FILTER;
               end else if (wait_q == WAIT_MAX) begin
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            FILTER: begin
               // FILTER spans FILT_LAT cycles starting with the filt_en cycle
               if (lat_q == LAT_MAX) state_q <= OUTPUT;
               else                  lat_q   <= lat_q + 4'd1;
            end
            OUTPUT: begin
               dac_data_q   <= fon_q ? bus.filt_out : filt_in_q;
               dac_valid_q  <= 1'b1;
               sample_cnt_q <= sample_cnt_d;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.adc_den   = den_q;
   assign bus.adc_daddr = ADC_ADDR;
   assign bus.filt_in   = filt_in_q;
   assign bus.filt_en   = fen_q;
   assign bus.dac_data  = dac_data_q;
   assign bus.dac_valid = dac_valid_q;
   assign timeout_err   = timeout_q;
   assign overrun_err   = overrun_q;
   assign sample_cnt    = sample_cnt_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: ADC/FIR behavioural models, a reference
// tick counter, and a scoreboard of expected DAC words per sample.
module tb_fir_sample_sequencer;
   localparam int CLK_DIV = 16;
   localparam int FLAT    = 4;
   localparam int DTO     = 255;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        filt_on = 1'b0;
   logic        timeout_err, overrun_err, timeout_err2, overrun_err2;
   logic [15:0] sample_cnt, sample_cnt2;

   logic [15:0] adc_do_v   = 16'hA5F0;
   logic [7:0]  filt_val   = 8'h3C;
   int          drdy_dly   = 1;
   logic        drdy_force = 1'b0;
   int          cd, cd2;
   logic [15:0] fen_sr = '0;
   logic [15:0] tcnt;
   logic        tb_tick;
   logic [15:0] sc_model = 16'd0;
   exp_t        sbq[$];
   exp_t        mon_e;
   logic        prev_den = 1'b0, prev_fen = 1'b0;
   int          vectors = 0, errors = 0;

   fir_sample_sequencer_if if1();
   fir_sample_sequencer_if if2();

   always #5 clk = ~clk;

   fir_sample_sequencer #(.CLK_DIV(CLK_DIV), .FILT_LAT(FLAT), .DRDY_TIMEOUT(DTO),
                          .ADC_ADDR(7'h16), .CNT_RST(16'h0000)) u_dut (
      .clk(clk), .rst(rst), .filt_on(filt_on), .bus(if1),
      .timeout_err(timeout_err), .overrun_err(overrun_err), .sample_cnt(sample_cnt));

   // second instance preloaded near the counter wrap point
   fir_sample_sequencer #(.CLK_DIV(CLK_DIV), .FILT_LAT(FLAT), .DRDY_TIMEOUT(DTO),
                          .ADC_ADDR(7'h16), .CNT_RST(16'hFFFF)) u_dut_wrap (
      .clk(clk), .rst(rst), .filt_on(filt_on), .bus(if2),
      .timeout_err(timeout_err2), .overrun_err(overrun_err2), .sample_cnt(sample_cnt2));

   // ADC model: drdy drdy_dly cycles after den (0 = never)
   always @(posedge clk or posedge rst) begin
      if (rst)              cd <= 0;
      else if (if1.adc_den) cd <= drdy_dly;
      else if (cd != 0)     cd <= cd - 1;
   end
   always @(posedge clk or posedge rst) begin
      if (rst)              cd2 <= 0;
      else if (if2.adc_den) cd2 <= drdy_dly;
      else if (cd2 != 0)    cd2 <= cd2 - 1;
   end
   assign if1.adc_do   = adc_do_v;
   assign if1.adc_drdy = (cd == 1) || drdy_force;
   assign if2.adc_do   = adc_do_v;
   assign if2.adc_drdy = (cd2 == 1);

   // FIR model: output valid only exactly FLAT cycles after filt_en
   always @(posedge clk) fen_sr <= {fen_sr[14:0], if1.filt_en};
   assign if1.filt_out = fen_sr[FLAT-1] ? filt_val : 8'hEE;
   assign if2.filt_out = filt_val;

   // reference sample-period tick
   always @(posedge clk or posedge rst) begin
      if (rst) tcnt <= 16'd0;
      else     tcnt <= tb_tick ? 16'd0 : tcnt + 16'd1;
   end
   assign tb_tick = (tcnt == 16'(CLK_DIV - 1));

   // scoreboard pop on every DAC strobe, plus strobe-width watch
   always @(negedge clk) begin
      if (!rst && if1.dac_valid === 1'b1) begin
         vectors++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dac_valid got data=%h cnt=%h, required no strobe",
                     if1.dac_data, sample_cnt);
         end else begin
            mon_e = sbq.pop_front();
            if (if1.dac_data !== mon_e.data || sample_cnt !== mon_e.cnt) begin
               errors++;
               $display("FAIL dac_output got data=%h cnt=%h, required data=%h cnt=%h",
                        if1.dac_data, sample_cnt, mon_e.data, mon_e.cnt);
            end
         end
      end
      if ((prev_den && if1.adc_den) || (prev_fen && if1.filt_en)) begin
         errors++;
         $display("FAIL strobe_width den=%b filt_en=%b high two cycles", if1.adc_den, if1.filt_en);
      end
      prev_den = if1.adc_den;
      prev_fen = if1.filt_en;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired, required run to finish");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      drdy_force = 1'b0;
      repeat (2) @(negedge clk);
      sbq.delete();
      sc_model = 16'd0;
      rst = 1'b0;
   endtask

   // drive one sample; lat = tick->dac_valid cycles (-1 if none)
   task automatic run_sample(input logic fon, input int dly, input bit toggle,
                             input bit expect_out, output int lat, output bit den_ok);
      int n;
      filt_on = fon;
      drdy_dly = dly;
      lat = -1;
      den_ok = 1'b0;
      n = 0;
      while (!tb_tick && n < 4 * CLK_DIV) begin @(negedge clk); n++; end
      if (!tb_tick) return;
      if (expect_out) begin
         sbq.push_back('{data: (fon ? filt_val : adc_do_v[15:8]), cnt: sc_model + 16'd1});
         sc_model = sc_model + 16'd1;
      end
      @(negedge clk);
      den_ok = (if1.adc_den === 1'b1);
      if (toggle) filt_on = ~fon;
      if (expect_out) begin
         n = 1;
         while (if1.dac_valid !== 1'b1 && n < dly + FLAT + 40) begin @(negedge clk); n++; end
         if (if1.dac_valid === 1'b1) lat = n;
      end else begin
         repeat (DTO + 8) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if ({if1.adc_den, if1.filt_en, if1.dac_valid, if1.filt_in, if1.dac_data,
           sample_cnt, timeout_err, overrun_err} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs got den=%b fen=%b dv=%b fin=%h dac=%h cnt=%h to=%b ov=%b, required all 0",
                  if1.adc_den, if1.filt_en, if1.dac_valid, if1.filt_in, if1.dac_data,
                  sample_cnt, timeout_err, overrun_err);
      end
      vectors++;
      if (sample_cnt2 !== 16'hFFFF) begin
         errors++; $display("FAIL reset_preload got %h required ffff", sample_cnt2);
      end
      vectors++;
      if (if1.adc_daddr !== 7'h16) begin
         errors++; $display("FAIL daddr got %h required 16", if1.adc_daddr);
      end
      rst = 1'b0;
   endtask

   task automatic test_filtered();
      int lat; bit ok;
      adc_do_v = 16'hA5F0; filt_val = 8'h3C;
      run_sample(1'b1, 1, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 8) begin
         errors++; $display("FAIL filtered_latency got den_ok=%b lat=%0d required 1/8", ok, lat);
      end
      vectors++;
      if (if1.filt_in !== 8'hA5 || if1.dac_data !== 8'h3C || sample_cnt !== 16'd1) begin
         errors++;
         $display("FAIL filtered_data got fin=%h dac=%h cnt=%h required a5/3c/0001",
                  if1.filt_in, if1.dac_data, sample_cnt);
      end
      vectors++;
      if (overrun_err !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL filtered_flags got ov=%b to=%b required 0/0", overrun_err, timeout_err);
      end
   endtask

   task automatic test_raw_toggle();
      int lat; bit ok;
      run_sample(1'b0, 1, 1'b1, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 8 || if1.dac_data !== 8'hA5) begin
         errors++; $display("FAIL raw_toggle got lat=%0d dac=%h required 8/a5", lat, if1.dac_data);
      end
      adc_do_v = 16'h5A3F; filt_val = 8'hC3;
      run_sample(1'b1, 2, 1'b1, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 9 || if1.dac_data !== 8'hC3) begin
         errors++; $display("FAIL filt_toggle got lat=%0d dac=%h required 9/c3", lat, if1.dac_data);
      end
      run_sample(1'b0, 3, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 10 || if1.dac_data !== 8'h5A) begin
         errors++; $display("FAIL raw_dly3 got lat=%0d dac=%h required 10/5a", lat, if1.dac_data);
      end
   endtask

   task automatic test_stray_drdy();
      int lat; bit ok;
      adc_do_v = 16'h7E00;
      @(negedge clk); drdy_force = 1'b1;
      @(negedge clk); drdy_force = 1'b0;
      vectors++;
      if (if1.filt_en !== 1'b0 || if1.filt_in !== 8'h5A) begin
         errors++; $display("FAIL stray_drdy got fen=%b fin=%h required 0/5a", if1.filt_en, if1.filt_in);
      end
      run_sample(1'b0, 1, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 8 || sample_cnt !== sc_model) begin
         errors++; $display("FAIL after_stray got lat=%0d cnt=%h required 8/%h", lat, sample_cnt, sc_model);
      end
   endtask

   task automatic test_timeout();
      int lat; bit ok; int n;
      do_reset();
      adc_do_v = 16'hA5F0; filt_val = 8'h3C;
      run_sample(1'b1, 1, 1'b0, 1'b1, lat, ok);
      filt_on = 1'b1; drdy_dly = 0;
      n = 0;
      while (!tb_tick && n < 4 * CLK_DIV) begin @(negedge clk); n++; end
      @(negedge clk);
      repeat (256) @(negedge clk);
      vectors++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("FAIL timeout_early got %b required 0", timeout_err);
      end
      @(negedge clk);
      vectors++;
      if (timeout_err !== 1'b1) begin
         errors++; $display("FAIL timeout_set got %b required 1", timeout_err);
      end
      vectors++;
      if (if1.dac_data !== 8'h3C || if1.dac_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_hold got dac=%h dv=%b required 3c/0", if1.dac_data, if1.dac_valid);
      end
      drdy_dly = 1;
      run_sample(1'b0, 1, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 8 || timeout_err !== 1'b1) begin
         errors++; $display("FAIL after_timeout got lat=%0d to=%b required 8/1", lat, timeout_err);
      end
   endtask

   task automatic test_drdy_boundary();
      int lat; bit ok;
      do_reset();
      run_sample(1'b1, 256, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 263 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL drdy_at_limit got lat=%0d to=%b required 263/0", lat, timeout_err);
      end
      run_sample(1'b1, 257, 1'b0, 1'b0, lat, ok);
      vectors++;
      if (timeout_err !== 1'b1 || sample_cnt !== 16'd1) begin
         errors++; $display("FAIL drdy_past_limit got to=%b cnt=%h required 1/0001", timeout_err, sample_cnt);
      end
   endtask

   task automatic test_overrun();
      int lat; bit ok;
      do_reset();
      run_sample(1'b1, 20, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 27 || overrun_err !== 1'b1 || sample_cnt !== 16'd1) begin
         errors++; $display("FAIL overrun got lat=%0d ov=%b cnt=%h required 27/1/0001", lat, overrun_err, sample_cnt);
      end
      run_sample(1'b1, 1, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (!ok || lat !== 8 || sample_cnt !== 16'd2 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL after_overrun got lat=%0d cnt=%h to=%b required 8/0002/0", lat, sample_cnt, timeout_err);
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit ok; int n;
      filt_on = 1'b1; drdy_dly = 1;
      n = 0;
      while (!tb_tick && n < 4 * CLK_DIV) begin @(negedge clk); n++; end
      n = 0;
      while (if1.filt_en !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      vectors++;
      if (if1.filt_en !== 1'b1) begin
         errors++; $display("FAIL reach_filter got fen=%b required 1", if1.filt_en);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({if1.adc_den, if1.filt_en, if1.dac_valid, if1.filt_in, if1.dac_data,
           sample_cnt, timeout_err, overrun_err} !== 37'd0) begin
         errors++;
         $display("FAIL mid_reset got dv=%b fin=%h dac=%h cnt=%h to=%b ov=%b required all 0",
                  if1.dac_valid, if1.filt_in, if1.dac_data, sample_cnt, timeout_err, overrun_err);
      end
      repeat (3) @(negedge clk);
      sbq.delete();
      sc_model = 16'd0;
      rst = 1'b0;
      adc_do_v = 16'hA5F0; filt_val = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         run_sample(1'b1, 1, 1'b0, 1'b1, lat, ok);
         vectors++;
         if (!ok || lat !== 8) begin
            errors++; $display("FAIL post_reset_sample%0d got den_ok=%b lat=%0d required 1/8", i, ok, lat);
         end
      end
      vectors++;
      if (sample_cnt !== 16'd3) begin
         errors++; $display("FAIL post_reset_count got %h required 0003", sample_cnt);
      end
   endtask

   task automatic test_wrap();
      int lat; bit ok;
      do_reset();
      vectors++;
      if (sample_cnt2 !== 16'hFFFF) begin
         errors++; $display("FAIL wrap_preload got %h required ffff", sample_cnt2);
      end
      adc_do_v = 16'hA5F0;
      run_sample(1'b0, 1, 1'b0, 1'b1, lat, ok);
      vectors++;
      if (sample_cnt2 !== 16'h0000 || if2.dac_data !== 8'hA5 || if2.dac_valid !== 1'b1 ||
          timeout_err2 !== 1'b0 || overrun_err2 !== 1'b0) begin
         errors++;
         $display("FAIL wrap got cnt=%h dac=%h dv=%b to=%b ov=%b required 0000/a5/1/0/0",
                  sample_cnt2, if2.dac_data, if2.dac_valid, timeout_err2, overrun_err2);
      end
   endtask

   initial begin
      test_reset();
      test_filtered();
      test_raw_toggle();
      test_stray_drdy();
      test_timeout();
      test_drdy_boundary();
      test_overrun();
      test_reset_mid();
      test_wrap();
      repeat (4) @(negedge clk);
      vectors++;
      if (sbq.size() != 0) begin
         errors++; $display("FAIL missing_dac_valid got %0d pending required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
